// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider.
// Divides a 2W-bit dividend by a W-bit divisor, one quotient bit per clock,
// MSB first. Divide-by-zero and quotient overflow are detected at accept time
// and answered in one cycle. Valid/ready handshake on both sides.
module seq_divider #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [W:0]     rem_p;     // partial remainder, one guard bit
  logic [W-1:0]   shreg;     // low dividend half, consumed MSB first
  logic [W-1:0]   dvs;       // divisor captured at accept
  logic [CW-1:0]  cnt;       // iterations left
  logic [W:0]     trial;
  logic [W:0]     diff;
  logic           qbit;
  logic           zero_in;
  logic           ovf_in;

  assign zero_in = (divisor == '0);
  // Quotient fits in W bits only if the upper dividend half is below divisor.
  assign ovf_in  = (dividend[2*W-1:W] >= divisor);
  assign trial   = {rem_p[W-1:0], shreg[W-1]};
  assign diff    = trial - {1'b0, dvs};
  assign qbit    = (trial >= {1'b0, dvs});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (zero_in || ovf_in) state_nxt = DONE;
          else                   state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, restoring iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_p       <= '0;
      shreg       <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs         <= divisor;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (zero_in) begin
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[W-1:0];
            end else if (ovf_in) begin
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[W-1:0];
            end else begin
              rem_p    <= {1'b0, dividend[2*W-1:W]};
              shreg    <= dividend[W-1:0];
              cnt      <= CW'(W);
              quotient <= '0;
            end
          end
        end
        CALC: begin
          rem_p    <= qbit ? diff : trial;
          shreg    <= {shreg[W-2:0], 1'b0};
          quotient <= {quotient[W-2:0], qbit};
          cnt      <= cnt - CW'(1);
          // Final remainder is below divisor, so the guard bit is zero.
          if (cnt == CW'(1)) remainder <= qbit ? diff[W-1:0] : trial[W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=4): directed cases, back-pressure,
// mid-operation reset and a sweep of every legal dividend/divisor pair with
// random handshake gaps, all checked against integer division.
module tb_seq_divider;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int vectors = 0;
  int miscompares = 0;

  seq_divider #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the error rules.
  task automatic model(input int dd, input int ds, output int q, output int r,
                       output bit z, output bit o);
    z = (ds == 0);
    o = !z && (dd / ds) > (2**W - 1);
    if (z || o) begin
      q = 2**W - 1;
      r = dd % (2**W);
    end else begin
      q = dd / ds;
      r = dd % ds;
    end
  endtask

  // One full transaction: optional idle gap, accept, latency, result, hold, handshake.
  task automatic run_op(input int dd, input int ds, input int gap, input int hold);
    int q, r, lat;
    bit z, o;
    logic [W-1:0] q0, r0;
    model(dd, ds, q, r, z, o);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 8'($urandom);
    end
    @(negedge clk);
    dividend  = 8'(dd);
    divisor   = 4'(ds);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);   // must not disturb the running operation
    divisor  = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), (z || o) ? 1 : W + 1);
    chk("quotient", 32'(quotient), 32'(q));
    chk("remainder", 32'(remainder), 32'(r));
    chk("div_by_zero", 32'(div_by_zero), 32'(z));
    chk("overflow", 32'(overflow), 32'(o));
    if (!z && !o) chk("invariant", 32'(quotient) * 32'(ds) + 32'(remainder), 32'(dd));
    q0 = quotient;
    r0 = remainder;
    repeat (hold) begin
      in_valid = 1'b1;          // ignored while a result is pending
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_q", 32'(quotient), 32'(q0));
      chk("hold_r", 32'(remainder), 32'(r0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("handshake_valid", 32'(out_valid), 0);
    chk("handshake_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(143, 12, 0, 0);
    run_op(225, 15, 1, 0);
    run_op(200, 12, 0, 0);
    run_op(77, 0, 0, 0);
    run_op(255, 1, 0, 1);
    run_op(0, 1, 0, 0);
    run_op(15, 1, 0, 0);
    run_op(16, 1, 0, 0);
    run_op(143, 12, 0, 10);

    // Abort in the middle of an operation.
    @(negedge clk);
    dividend = 8'd143;
    divisor  = 4'd12;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("calc_in_ready", 32'(in_ready), 0);
    chk("calc_out_valid", 32'(out_valid), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    chk("abort_flags", {30'd0, div_by_zero, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_no_result", 32'(out_valid), 0);
    end
    run_op(56, 7, 0, 0);

    // Every non-overflowing pair, random gaps on both sides.
    for (int ds = 1; ds < 16; ds++)
      for (int dd = 0; dd < ds * 16; dd++)
        run_op(dd, ds, $urandom_range(0, 2), $urandom_range(0, 2));

    // Arbitrary operands, including error cases.
    for (int k = 0; k < 200; k++)
      run_op($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1),
             $urandom_range(0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider, the inverse operator of the team's combinational array multiplier.
- Takes a 2W-bit dividend, such as a multiplier product, and a W-bit divisor.
- Returns a W-bit quotient and a W-bit remainder.
- Uses a valid/ready handshake on both sides, so it can sit downstream of the multiplier in arithmetic check/verification datapaths.

Parameters:
- W, 4, operand width. Dividend is 2W bits; divisor, quotient and remainder are W bits. Legal range is W >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- dividend  input  2W  unsigned dividend
- divisor  input  W  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  W  unsigned quotient
- remainder  output  W  unsigned remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  true quotient does not fit in W bits

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0 the following hold immediately, independent of clk:
  - state=IDLE, in_ready=1, out_valid=0
  - quotient=0, remainder=0, div_by_zero=0, overflow=0
  - internal partial remainder, shift register and iteration counter all cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - The operands are accepted on the rising edge where in_valid=1. The operands are registered at that edge.
  - If divisor==0: next state DONE, div_by_zero=1, overflow=0, quotient={W{1}}, remainder=dividend[W-1:0].
  - Else if dividend[2W-1:W] >= divisor: next state DONE, overflow=1, div_by_zero=0, quotient={W{1}}, remainder=dividend[W-1:0].
  - Else: next state CALC. Partial remainder R (W+1 bits) is loaded with {0, dividend[2W-1:W]}. The low half dividend[W-1:0] is loaded into the shift register. The counter is set to W.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle: T = {R[W-1:0], next dividend bit, MSB first}.
  - If T >= {0,divisor}, then R = T - divisor and the quotient bit is 1; else R = T and the quotient bit is 0.
  - The quotient bit is shifted into the LSB of the quotient register. The counter is decremented.
  - After exactly W iterations, next state DONE. Remainder = R[W-1:0]. Both error flags are 0.
- Latency, measured from the accept edge:
  - Normal operation: out_valid rises after W+1 rising edges (W iterations plus the DONE transition), i.e. W+1 cycles.
  - Error cases: out_valid rises after 1 edge.
- DONE:
  - out_valid=1, in_ready=0. quotient, remainder and flags are held stable.
  - On an edge with out_ready=1: next state IDLE, out_valid falls.
  - While out_ready=0, the block holds indefinitely with all outputs stable.
- Output timing: quotient, remainder and flags keep their last values after DONE until the next acceptance. They are only meaningful while out_valid=1.
- Simultaneous events: in DONE, in_valid is ignored because in_ready=0. A back-to-back operation is accepted at the earliest one cycle after the result handshake.
- Input changes: changes on dividend/divisor while in CALC or DONE have no effect.
- Arithmetic invariant: for every non-error result, dividend == quotient*divisor + remainder and remainder < divisor.
- Reset mid-operation: asserting rst_n in CALC or DONE aborts immediately. All outputs return to their reset values and no result is emitted.

Test Plan:
- W=4, dividend=143, divisor=12, out_ready=1 -> after 5 cycles out_valid=1, quotient=11, remainder=11, flags 0.
- dividend=225, divisor=15 -> quotient=15, remainder=0. Then dividend=200, divisor=12 -> overflow=1, quotient=15, remainder=8, out_valid 1 cycle after accept.
- dividend=77, divisor=0 -> div_by_zero=1, overflow=0, quotient=15, remainder=13.
- Back-pressure: 143/12 with out_ready=0 for 10 cycles -> out_valid stays 1, outputs stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-CALC: pulse rst_n low 2 cycles after accept -> in_ready=1, out_valid=0 and all outputs 0 asynchronously. A fresh 56/7 afterwards -> quotient=8, remainder=0.
- Exhaustive randomised check, W=4: all dividend < divisor*16 with divisor 1..15, random in_valid/out_ready gaps -> invariant holds and each accepted operation yields exactly one result, in order.
